// File: rtl/noc_flit_injector.sv
// Network-interface transmitter: packetizes payload words into head/body/tail flits on two VCs
// with credit flow control. Define NOC_INJ_VC_RR_EN for round-robin VC choice (default: VC0 priority).
module noc_flit_injector #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  my_xpos,
  input  logic [1:0]  my_ypos,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [1:0]  s_dst_x,
  input  logic [1:0]  s_dst_y,
  output logic [34:0] odata,
  output logic        ovalid,
  output logic        ovch,
  input  logic [1:0]  iack,
  input  logic [1:0]  ilck,
  output logic        credit_err
);

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t          state_reg, state_next;
  logic            cur_vc_reg, cur_vc_next;
  logic [1:0][3:0] credit_reg;
  logic            credit_err_reg;
  logic [1:0]      credit_ok;
  logic [1:0]      eligible;
  logic [1:0]      dec;
  logic [1:0]      inc;
  logic [1:0]      err_set;
  logic            chosen;
  logic            issue;
  logic            issue_vc;
  logic            head_issue;
  logic [34:0]     flit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      assign credit_ok[gi] = (credit_reg[gi] != 4'd0);
      assign eligible[gi]  = credit_ok[gi] && !ilck[gi];
      assign dec[gi]       = issue && (issue_vc == 1'(gi));
      // An ack with a full counter is a protocol error and must not overflow it
      assign err_set[gi]   = iack[gi] && (credit_reg[gi] == DEPTH_L);
      assign inc[gi]       = iack[gi] && !err_set[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < 2; v++) credit_reg[v] <= DEPTH_L;
      credit_err_reg <= 1'b0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (dec[v] && !inc[v])
          credit_reg[v] <= credit_reg[v] - 4'd1;
        else if (inc[v] && !dec[v])
          credit_reg[v] <= credit_reg[v] + 4'd1;
      end
      if (|err_set) credit_err_reg <= 1'b1;
    end
  end

  assign credit_err = credit_err_reg;
  assign head_issue = issue && (state_reg == IDLE);

`ifdef NOC_INJ_VC_RR_EN
  logic rr_ptr_reg;

  always_comb begin
    chosen = !eligible[0];
    if (&eligible) chosen = rr_ptr_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rr_ptr_reg <= 1'b0;
    else if (head_issue) rr_ptr_reg <= !chosen;
  end
`else
  assign chosen = !eligible[0];
`endif

  always_comb begin
    state_next  = state_reg;
    cur_vc_next = cur_vc_reg;
    s_ready     = 1'b0;
    issue       = 1'b0;
    issue_vc    = cur_vc_reg;
    flit        = '0;
    case (state_reg)
      IDLE: begin
        // Head only peeks the destination; the payload word stays pending
        if (s_valid && (|eligible)) begin
          issue       = 1'b1;
          issue_vc    = chosen;
          cur_vc_next = chosen;
          flit        = {2'b01, s_dst_x, s_dst_y, my_xpos, my_ypos, 25'd0};
          state_next  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        s_ready = credit_ok[cur_vc_reg];
        if (s_valid && s_ready) begin
          issue = 1'b1;
          flit  = {(s_last ? 2'b10 : 2'b00), 1'b0, s_data};
          if (s_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cur_vc_reg <= 1'b0;
      ovalid     <= 1'b0;
      odata      <= '0;
      ovch       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cur_vc_reg <= cur_vc_next;
      ovalid     <= issue;
      if (issue) begin
        odata <= flit;
        ovch  <= issue_vc;
      end
    end
  end

endmodule

// File: tb/tb_noc_flit_injector.sv
// Directed self-checking bench for noc_flit_injector (DEPTH=4, node at (1,2)).
module tb_noc_flit_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  my_xpos, my_ypos;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [1:0]  s_dst_x, s_dst_y;
  logic [34:0] odata;
  logic        ovalid;
  logic        ovch;
  logic [1:0]  iack;
  logic [1:0]  ilck;
  logic        credit_err;

  int vectors = 0;
  int miscompares = 0;

  noc_flit_injector #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .s_dst_x(s_dst_x), .s_dst_y(s_dst_y), .odata(odata), .ovalid(ovalid),
    .ovch(ovch), .iack(iack), .ilck(ilck), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  task automatic ack(input logic [1:0] v, input int n);
    iack = v;
    for (int i = 0; i < n; i++) tick();
    iack = 2'b00;
  endtask

  logic [34:0] head_exp;
  logic        rr_exp [3];

  initial begin
`ifdef NOC_INJ_VC_RR_EN
    rr_exp[0] = 1'b0; rr_exp[1] = 1'b1; rr_exp[2] = 1'b0;
`else
    rr_exp[0] = 1'b0; rr_exp[1] = 1'b0; rr_exp[2] = 1'b0;
`endif
    rst = 1'b1; my_xpos = 2'd1; my_ypos = 2'd2;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_dst_x = '0; s_dst_y = '0;
    iack = 2'b00; ilck = 2'b00;
    tick(); tick();
    check("rst_ovalid", ovalid, 0);
    check("rst_odata", odata, 0);
    check("rst_ovch", ovch, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_credit_err", credit_err, 0);
    rst = 1'b0;
    tick();

    // Single packet: head, body, tail on VC0
    head_exp = {2'b01, 2'd3, 2'd0, 2'd1, 2'd2, 25'd0};
    s_valid = 1'b1; s_dst_x = 2'd3; s_dst_y = 2'd0; s_data = 32'hA5A5A5A5; s_last = 1'b0;
    tick();
    check("pkt_head_valid", ovalid, 1);
    check("pkt_head_data", odata, head_exp);
    check("pkt_head_vch", ovch, 0);
    check("pkt_ready", s_ready, 1);
    tick();
    check("pkt_body", odata, {2'b00, 1'b0, 32'hA5A5A5A5});
    s_data = 32'h12345678; s_last = 1'b1;
    tick();
    check("pkt_tail", odata, {2'b10, 1'b0, 32'h12345678});
    check("pkt_tail_valid", ovalid, 1);
    s_valid = 1'b0;
    check("pkt_credit0", dut.credit_reg[0], 1);
    tick();
    check("pkt_idle_valid", ovalid, 0);
    ack(2'b01, 3);
    check("restore_credit0", dut.credit_reg[0], 4);

    // Credit exhaustion: 5-word packet against 4 credits
    s_valid = 1'b1; s_last = 1'b0; s_data = 32'h0000_0001;
    tick(); tick(); tick(); tick();
    check("exh_last_valid", ovalid, 1);
    check("exh_ready_low", s_ready, 0);
    tick();
    check("exh_stall", ovalid, 0);
    ack(2'b01, 1);
    check("exh_ack_ready", s_ready, 1);
    tick();
    check("exh_one_more", ovalid, 1);
    check("exh_ready_low2", s_ready, 0);
    tick();
    check("exh_stall2", ovalid, 0);
    s_last = 1'b1;
    ack(2'b01, 1);
    tick();
    check("exh_tail", odata[34:33], 2'b10);
    s_valid = 1'b0; s_last = 1'b0;
    ack(2'b01, 4);
    check("exh_restore", dut.credit_reg[0], 4);

    // Lock: VC0 locked forces VC1; both locked blocks the head
    ilck = 2'b01; s_valid = 1'b1; s_last = 1'b1; s_dst_x = 2'd0; s_dst_y = 2'd1; s_data = 32'hDEADBEEF;
    tick();
    check("lck_head_valid", ovalid, 1);
    check("lck_head_vch", ovch, 1);
    tick();
    check("lck_tail_vch", ovch, 1);
    check("lck_tail_type", odata[34:33], 2'b10);
    ilck = 2'b11;
    tick();
    check("lck_both_a", ovalid, 0);
    tick();
    check("lck_both_b", ovalid, 0);
    ilck = 2'b10;
    tick();
    check("lck_drop_valid", ovalid, 1);
    check("lck_drop_vch", ovch, 0);
    tick();
    s_valid = 1'b0; ilck = 2'b00;
    ack(2'b11, 2);
    check("lck_credit1", dut.credit_reg[1], 4);

    // Fresh reset so the RR pointer starts at 0
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int p = 0; p < 3; p++) begin
      s_valid = 1'b1; s_last = 1'b1; s_data = 32'(p);
      tick();
      check($sformatf("rr_head%0d_vch", p), ovch, rr_exp[p]);
      tick();
      check($sformatf("rr_tail%0d_vch", p), ovch, rr_exp[p]);
      s_valid = 1'b0;
      ack(rr_exp[p] ? 2'b10 : 2'b01, 2);
    end

    // Simultaneous ack and issue at credit 1, then an excess ack
    s_valid = 1'b1; s_last = 1'b0; s_data = 32'h55;
    tick(); tick(); tick();
    check("sim_credit1", dut.credit_reg[0], 1);
    s_last = 1'b1; iack = 2'b01;
    tick();
    iack = 2'b00; s_valid = 1'b0;
    check("sim_issue", ovalid, 1);
    check("sim_credit_hold", dut.credit_reg[0], 1);
    ack(2'b01, 3);
    check("sim_no_err", credit_err, 0);
    ack(2'b01, 1);
    check("err_set", credit_err, 1);
    check("err_credit_full", dut.credit_reg[0], 4);
    tick();
    check("err_sticky", credit_err, 1);

    // Reset mid-packet after the head
    s_valid = 1'b1; s_last = 1'b0; s_data = 32'h77;
    tick();
    check("mid_head", ovalid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ovalid", ovalid, 0);
    check("mid_rst_credit", dut.credit_reg[0], 4);
    check("mid_rst_err", credit_err, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_fresh_head", odata[34:33], 2'b01);
    check("mid_fresh_valid", ovalid, 1);
    s_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/noc_flit_injector.md
# noc_flit_injector

Network-interface transmitter that drives the local injection port (port 4) of `router_wrap`. It packetizes 32-bit payload words from user logic into 35-bit wormhole flits and selects one of the two virtual channels per packet. It enforces credit-based flow control from the router's per-VC acknowledgements and honours the router's per-VC lock indications.

## Interface
Parameters:
- `DEPTH`, default 4: router input-buffer depth per VC, which is the initial credit count. Legal range is 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `my_xpos`  in  2  this node's X coordinate. Static.
- `my_ypos`  in  2  this node's Y coordinate. Static.
- `s_valid`  in  1  payload word valid.
- `s_ready`  out  1  payload word accepted when high together with `s_valid`.
- `s_data`  in  32  payload word.
- `s_last`  in  1  this word is the last of its packet.
- `s_dst_x`  in  2  destination X. Sampled only on the head-issue cycle.
- `s_dst_y`  in  2  destination Y. Sampled only on the head-issue cycle.
- `odata`  out  35  flit to the router's `idata_4`.
- `ovalid`  out  1  flit valid, to `ivalid_4`.
- `ovch`  out  1  VC of the flit, to `ivch_4`.
- `iack`  in  2  per-VC credit return, from `oack_4`. One pulse returns one credit.
- `ilck`  in  2  per-VC lock, from `olck_4`. While high, no new packet may start on that VC.
- `credit_err`  out  1  sticky flag: a credit was returned while the counter was already at `DEPTH`.

## Operation
Flit format:
- Bits [34:33] hold the type: 01 = head, 00 = body, 10 = tail.
- Head flit fields:
  - [32:31] dst_x
  - [30:29] dst_y
  - [28:27] src_x (`my_xpos`)
  - [26:25] src_y (`my_ypos`)
  - [24:0] = 0
- Body and tail flits: [32] = 0, [31:0] = `s_data`.
- Every packet is exactly one head flit followed by one or more payload flits. The final payload flit is the tail.

Credits:
- Each VC has a counter of width 4, reset to `DEPTH`.
- The counter is decremented on the cycle a flit is issued on that VC.
- The counter is incremented on `iack[v]`.
- A simultaneous issue and ack on the same VC leaves the counter unchanged.
- An ack arriving when the counter equals `DEPTH` is ignored and sets `credit_err`. `credit_err` is cleared only by `rst`.

VC eligibility:
- VC v is eligible when `credit[v] > 0` and `ilck[v] == 0`.

State machine (states IDLE and PAYLOAD):
- IDLE:
  - `s_ready` = 0.
  - If `s_valid` is high and at least one VC is eligible: choose a VC, issue the head flit, latch the chosen VC into `cur_vc`, and go to PAYLOAD.
  - The head flit is issued without consuming the word; it only peeks `s_dst_x`/`s_dst_y`.
- PAYLOAD:
  - `s_ready` = (`credit[cur_vc] > 0`). `ilck` is ignored mid-packet.
  - On an `s_valid && s_ready` handshake, issue a body flit, or a tail flit if `s_last` is set.
  - After a tail, return to IDLE.
- Every issue decrements `credit[cur_vc]` or `credit[chosen]` as applicable.
- VC choice, when both VCs are eligible, is set by the macro (see Configuration).

## Timing
- `odata`, `ovalid` and `ovch` are registered. A flit issued in cycle N appears with `ovalid` = 1 in cycle N+1.
- `ovalid` is a one-cycle pulse per flit. With continuous input and credits, back-to-back flits occur every cycle.
- Head-to-first-payload spacing: minimum 1 cycle. The head is issued in IDLE, and the first payload can be accepted in the next cycle.
- `s_ready` is combinational from state and credit registers only, never from `s_valid`.
- An `iack` pulse in cycle N is usable for an issue in cycle N+1.
- Reset values: `ovalid` = 0, `odata` = 0, `ovch` = 0, `s_ready` = 0, `credit_err` = 0, state = IDLE, credits = `DEPTH`, RR pointer = 0.
- Reset asserted mid-packet aborts the packet immediately and asynchronously. No tail is sent, and the router side is reset by the same reset.

## Configuration
- `NOC_INJ_VC_RR_EN` defined:
  - VC choice is round-robin.
  - A 1-bit pointer names the preferred VC and is used when both VCs are eligible.
  - After each head issue, the pointer becomes the complement of the VC chosen.
- `NOC_INJ_VC_RR_EN` undefined:
  - Fixed priority: VC0 whenever VC0 is eligible, else VC1.
  - No pointer flop exists.

## Test plan
- Single packet, DEPTH=4, my=(1,2):
  - Stimulus: dst=(3,0), words 0xA5A5A5A5 and 0x12345678 with last=1.
  - Required: three flits on VC0. Head = {2'b01, 2'd3, 2'd0, 2'd1, 2'd2, 25'b0}, then {2'b00, 1'b0, 0xA5A5A5A5}, then {2'b10, 1'b0, 0x12345678}. credit[0] goes from 4 to 1.
- Credit exhaustion, DEPTH=2, no acks:
  - Stimulus: a 4-word packet.
  - Required: head and 1 body issue, then `s_ready` = 0. An `iack[0]` pulse yields exactly one more flit.
- Lock:
  - Stimulus: `ilck` = 2'b01 while a packet is pending in IDLE.
  - Required: head goes on VC1. With `ilck` = 2'b11, no head issues until a lock drops.
- RR:
  - Stimulus: with `NOC_INJ_VC_RR_EN`, three 1-word packets with ample credits.
  - Required: VCs 0, 1, 0. Without the macro: VCs 0, 0, 0.
- Simultaneous ack and issue on VC0 at credit 1:
  - Required: the counter stays at 1.
  - Follow-up: an extra ack at credit = DEPTH sets `credit_err` = 1, and it remains set.
- Reset mid-packet after the head:
  - Required: `ovalid` drops immediately, credits return to DEPTH, and the next packet starts with a fresh head.
